fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_perf_cnt.sv | 35 +++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters in fetch_unit).
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        STALL   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
    localparam logic [3:0]  RMASK_WORD       = 4'b1111;

    // Fetch addresses are always whole instruction words.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter bank for the fetch unit.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_fetched,
    input  logic        inc_stall,
    input  logic        inc_discard,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_discard
);

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc);
        if (inc && (val != 32'hFFFF_FFFF)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

    // Count pushed instructions, stall cycles and dropped responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_discard <= '0;
        end else begin
            perf_fetched <= sat_inc(perf_fetched, inc_fetched);
            perf_stall   <= sat_inc(perf_stall, inc_stall);
            perf_discard <= sat_inc(perf_discard, inc_discard);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: walks the PC, issues one word read at a time to the
// I-cache, pushes returned instructions into instruction_q, and handles queue
// back-pressure and redirects (dropping responses that were already in flight).
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_stall/perf_discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ufp_addr,
    output logic [3:0]  ufp_rmask,
    input  logic [31:0] ufp_rdata,
    input  logic        ufp_resp,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_discard
`endif
);

    fetch_state_t state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  stale_q, stale_n;
    logic [31:0]  hold_q, hold_n;
    logic [3:0]   rmask_q, rmask_n;

    // While discarding, the cache still sees the address it was originally asked for.
    assign ufp_addr  = (state_q == DISCARD) ? stale_q : pc_q;
    assign ufp_rmask = rmask_q;

    // State, PC, stale-address, hold and request-mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            stale_q <= RESET_PC;
            hold_q  <= '0;
            rmask_q <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            stale_q <= stale_n;
            hold_q  <= hold_n;
            rmask_q <= rmask_n;
        end
    end

    // Next-state and queue outputs; a redirect overrides every other event.
    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        stale_n  = stale_q;
        hold_n   = hold_q;
        iq_push  = 1'b0;
        iq_inst  = '0;
        iq_pc    = '0;
        iq_flush = 1'b0;

        if (redirect_valid) begin
            iq_flush = 1'b1;
            pc_n     = word_align(redirect_pc);
            unique case (state_q)
                REQ: begin
                    // Without a response the old request is still live and must be drained.
                    if (!ufp_resp) begin
                        state_n = DISCARD;
                        stale_n = pc_q;
                    end
                end
                STALL: begin
                    state_n = REQ;
                    hold_n  = '0;
                end
                DISCARD: state_n = DISCARD;
                default: state_n = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (ufp_resp && !iq_full) begin
                        iq_push = 1'b1;
                        iq_inst = ufp_rdata;
                        iq_pc   = pc_q;
                        pc_n    = pc_q + PC_STEP;
                    end else if (ufp_resp) begin
                        hold_n  = ufp_rdata;
                        state_n = STALL;
                    end
                end
                STALL: begin
                    if (!iq_full) begin
                        iq_push = 1'b1;
                        iq_inst = hold_q;
                        iq_pc   = pc_q;
                        pc_n    = pc_q + PC_STEP;
                        hold_n  = '0;
                        state_n = REQ;
                    end
                end
                DISCARD: begin
                    if (ufp_resp) begin
                        state_n = REQ;
                    end
                end
                default: state_n = REQ;
            endcase
        end

        // A request is presented in every state except STALL.
        rmask_n = (state_n == STALL) ? 4'b0000 : RMASK_WORD;
    end

`ifdef FETCH_PERF_CNT_EN
    logic resp_drop;
    assign resp_drop = ufp_resp &&
                       ((state_q == DISCARD) || ((state_q == REQ) && redirect_valid));

    fetch_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .inc_fetched  (iq_push),
        .inc_stall    (state_q == STALL),
        .inc_discard  (resp_drop),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_discard (perf_discard)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural I-cache model plus a
// scoreboard of expected instruction_q pushes.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1eceb000;

    logic        clk;
    logic        rst;
    logic [31:0] ufp_addr;
    logic [3:0]  ufp_rmask;
    logic [31:0] ufp_rdata;
    logic        ufp_resp;
    logic        iq_full;
    logic        iq_push;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_discard;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .ufp_addr       (ufp_addr),
        .ufp_rmask      (ufp_rmask),
        .ufp_rdata      (ufp_rdata),
        .ufp_resp       (ufp_resp),
        .iq_full        (iq_full),
        .iq_push        (iq_push),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_flush       (iq_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_discard   (perf_discard)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] req_log[$];
    int          n_cmp, n_err;
    int          lat, resp_limit, n_resp, cnt, push_cnt, flush_cnt;
    bit          busy, ovr_en;
    logic [31:0] cur_addr, ovr_addr, ovr_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] req_at(input int i);
        if (req_log.size() > i) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hAAAA0000;
    endfunction

    task automatic expect_push(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int l, input int lim, input bit oe,
                            input logic [31:0] oa, input logic [31:0] od);
        @(posedge clk); #3;
        rst = 1'b1;
        iq_full = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        lat = l;
        resp_limit = lim;
        ovr_en = oe;
        ovr_addr = oa;
        ovr_data = od;
        repeat (2) @(posedge clk);
        #3;
        sb.delete();
        chk("rst_rmask", 32'(ufp_rmask), 0);
        chk("rst_addr", ufp_addr, RST_PC);
        chk("rst_push", 32'(iq_push), 0);
        chk("rst_flush", 32'(iq_flush), 0);
        chk("rst_inst", iq_inst, 0);
        chk("rst_pc", iq_pc, 0);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("rmask_after_rst", 32'(ufp_rmask), 32'hF);
    endtask

    task automatic wait_resp_at(input logic [31:0] a);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (ufp_resp && cur_addr == a) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("timeout_resp", 32'(ok), 1);
    endtask

    task automatic wait_accept_at(input logic [31:0] a);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (busy && cur_addr == a) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("timeout_accept", 32'(ok), 1);
    endtask

    task automatic wait_pushes(input int target);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (push_cnt >= target) break;
        end
        repeat (4) @(posedge clk);
        #2;
        chk("push_count", push_cnt, target);
        chk("sb_left", sb.size(), 0);
    endtask

    initial begin
        int base, fbase;
        rst = 1'b1;
        iq_full = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        ufp_resp = 1'b0;
        ufp_rdata = '0;
        lat = 1;
        resp_limit = 0;
        ovr_en = 1'b0;
        ovr_addr = '0;
        ovr_data = '0;
        busy = 1'b0;
        cnt = 0;
        n_resp = 0;
        cur_addr = '0;
        n_cmp = 0;
        n_err = 0;
        push_cnt = 0;
        flush_cnt = 0;

        fork
            // I-cache model: one request at a time, response strobe after lat cycles.
            forever begin
                @(posedge clk); #1;
                if (rst) begin
                    busy = 1'b0;
                    ufp_resp = 1'b0;
                    cnt = 0;
                    n_resp = 0;
                    req_log.delete();
                end else begin
                    if (ufp_resp) begin
                        ufp_resp = 1'b0;
                    end else if (busy) begin
                        if (cnt > 1) begin
                            cnt--;
                        end else if (n_resp < resp_limit) begin
                            ufp_resp = 1'b1;
                            ufp_rdata = (ovr_en && cur_addr == ovr_addr) ? ovr_data : dflt(cur_addr);
                            busy = 1'b0;
                            n_resp++;
                        end
                    end
                    if (!busy && !ufp_resp && ufp_rmask == 4'hF) begin
                        busy = 1'b1;
                        cur_addr = ufp_addr;
                        cnt = lat;
                        req_log.push_back(ufp_addr);
                    end
                end
            end
            // Push monitor against the scoreboard.
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (iq_flush) flush_cnt++;
                    if (iq_push) begin
                        push_cnt++;
                        chk("push_while_full", 32'(iq_full), 0);
                        if (sb.size() == 0) begin
                            chk("unexpected_push", 32'(iq_push), 0);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("push_pc", iq_pc, e.pc);
                            chk("push_inst", iq_inst, e.inst);
                        end
                    end
                end
            end
        join_none

        // 1: straight-line fetch
        do_reset(1, 3, 1'b0, '0, '0);
        base = push_cnt;
        expect_push(32'h1eceb000, dflt(32'h1eceb000));
        expect_push(32'h1eceb004, dflt(32'h1eceb004));
        expect_push(32'h1eceb008, dflt(32'h1eceb008));
        wait_pushes(base + 3);
        chk("s1_first_addr", req_at(0), RST_PC);
        chk("s1_fourth_addr", req_at(3), 32'h1eceb00c);

        // 2: queue full on the second response
        do_reset(1, 3, 1'b1, 32'h1eceb004, 32'hbabebabe);
        base = push_cnt;
        expect_push(32'h1eceb000, dflt(32'h1eceb000));
        expect_push(32'h1eceb004, 32'hbabebabe);
        expect_push(32'h1eceb008, dflt(32'h1eceb008));
        wait_resp_at(32'h1eceb004);
        iq_full = 1'b1;
        #1;
        chk("s2_no_push_resp", 32'(iq_push), 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            chk("s2_rmask_full", 32'(ufp_rmask), 0);
            chk("s2_no_push_full", 32'(iq_push), 0);
        end
        @(posedge clk); #2;
        iq_full = 1'b0;
        #1;
        chk("s2_push_release", 32'(iq_push), 1);
        chk("s2_inst_release", iq_inst, 32'hbabebabe);
        chk("s2_pc_release", iq_pc, 32'h1eceb004);
        wait_pushes(base + 3);
        chk("s2_next_addr", req_at(2), 32'h1eceb008);

        // 3: redirect with a request in flight, response two cycles later
        do_reset(2, 6, 1'b0, '0, '0);
        base = push_cnt;
        expect_push(32'h1eceb000, dflt(32'h1eceb000));
        expect_push(32'h1eceb004, dflt(32'h1eceb004));
        expect_push(32'h1eceb008, dflt(32'h1eceb008));
        expect_push(32'h1ecec100, dflt(32'h1ecec100));
        expect_push(32'h1ecec104, dflt(32'h1ecec104));
        wait_accept_at(32'h1eceb00c);
        fbase = flush_cnt;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1ecec100;
        #1;
        chk("s3_flush", 32'(iq_flush), 1);
        chk("s3_no_push", 32'(iq_push), 0);
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        chk("s3_stale_addr", ufp_addr, 32'h1eceb00c);
        wait_pushes(base + 5);
        chk("s3_flush_once", flush_cnt - fbase, 1);
        chk("s3_redirect_addr", req_at(4), 32'h1ecec100);

        // 4: redirect coincident with a response
        do_reset(1, 4, 1'b1, 32'h1eceb004, 32'hdeaddead);
        base = push_cnt;
        expect_push(32'h1eceb000, dflt(32'h1eceb000));
        expect_push(32'h1ecec200, dflt(32'h1ecec200));
        expect_push(32'h1ecec204, dflt(32'h1ecec204));
        wait_resp_at(32'h1eceb004);
        redirect_valid = 1'b1;
        redirect_pc = 32'h1ecec200;
        #1;
        chk("s4_no_push", 32'(iq_push), 0);
        chk("s4_flush", 32'(iq_flush), 1);
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        chk("s4_addr", ufp_addr, 32'h1ecec200);
        chk("s4_rmask", 32'(ufp_rmask), 32'hF);
        wait_pushes(base + 3);

        // 5: redirect while stalled (unaligned target is word aligned)
        do_reset(1, 4, 1'b1, 32'h1eceb004, 32'h12345678);
        base = push_cnt;
        expect_push(32'h1eceb000, dflt(32'h1eceb000));
        expect_push(32'h00000010, dflt(32'h00000010));
        expect_push(32'h00000014, dflt(32'h00000014));
        wait_resp_at(32'h1eceb004);
        iq_full = 1'b1;
        @(posedge clk); #2;
        iq_full = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h00000012;
        #1;
        chk("s5_no_push", 32'(iq_push), 0);
        chk("s5_flush", 32'(iq_flush), 1);
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        chk("s5_addr", ufp_addr, 32'h00000010);
        wait_pushes(base + 3);

        // 6: PC wraps past the top of the address space
        do_reset(1, 3, 1'b0, '0, '0);
        base = push_cnt;
        expect_push(32'hFFFFFFFC, dflt(32'hFFFFFFFC));
        expect_push(32'h00000000, dflt(32'h00000000));
        wait_resp_at(RST_PC);
        iq_full = 1'b1;
        @(posedge clk); #2;
        iq_full = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        wait_pushes(base + 2);
        chk("s6_wrap_addr", req_at(2), 32'h00000000);
`ifdef FETCH_PERF_CNT_EN
        chk("s6_perf_fetched", perf_fetched, 2);
        chk("s6_perf_discard", perf_discard, 0);
        chk("s6_perf_stall", perf_stall, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
